// File: rtl/nibble_serializer_pkg.sv
// Shared types and widths for the nibble serializer and its byte FIFO.
package nibble_serializer_pkg;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  function automatic logic [NIB_W-1:0] pick_nib(input logic [BYTE_W-1:0] b, input logic hi);
    return hi ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with registered pointers and occupancy; push/pop are
// assumed pre-qualified by the caller (no push when full, no pop when empty).
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/nibble_serializer.sv
// Byte-to-nibble serializer feeding the M1 consumer (C/x0/x1, ack from x2).
// Optional acknowledge-wait timeout is built when NIBSER_TIMEOUT_EN is defined.
module nibble_serializer
  import nibble_serializer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W-1:0]        in_data,
  output logic [BYTE_W-1:0]        cfg_out,
  output logic                     nib_valid,
  output logic [NIB_W-1:0]         nib_data,
  input  logic                     nib_ack,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
`ifdef NIBSER_TIMEOUT_EN
  ,
  output logic                     timeout_err
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic HI_FIRST = (MSB_FIRST != 0);

  // Valid/ready: a byte transfers on any rising edge where in_valid && in_ready;
  // in_ready depends only on the registered level, never on in_valid.
  logic              push, pop, fifo_full, fifo_empty;
  logic [BYTE_W-1:0] head;
  logic [LW-1:0]     fifo_level;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  byte_fifo #(.DEPTH(DEPTH), .W(BYTE_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (in_data),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] cfg_q, cfg_d;
  logic              nib_valid_q, nib_valid_d;
  logic [NIB_W-1:0]  nib_data_q, nib_data_d;
  logic              tmo, adv;

  assign adv = (state_q != IDLE) && (nib_ack || tmo);

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    pop         = 1'b0;
    nib_valid_d = 1'b0;
    nib_data_d  = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cfg_d   = head;
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (adv) state_d = SECOND;
      end
      SECOND: begin
        if (adv) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            cfg_d   = head;
            state_d = FIRST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Nibble outputs are registered from the next state so they line up with it.
    case (state_d)
      FIRST: begin
        nib_valid_d = 1'b1;
        nib_data_d  = pick_nib(cfg_d, HI_FIRST);
      end
      SECOND: begin
        nib_valid_d = 1'b1;
        nib_data_d  = pick_nib(cfg_d, !HI_FIRST);
      end
      default: begin
        nib_valid_d = 1'b0;
        nib_data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      nib_valid_q <= 1'b0;
      nib_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      nib_valid_q <= nib_valid_d;
      nib_data_q  <= nib_data_d;
    end
  end

`ifdef NIBSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_q, wait_d;
  logic          terr_q;

  // Fires on the cycle whose increment would reach TIMEOUT, so each nibble
  // is presented for exactly TIMEOUT cycles before the forced advance.
  assign tmo = (state_q != IDLE) && !nib_ack && (wait_q == TW'(TIMEOUT - 1));

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)                wait_d = '0;
    else if (state_q != IDLE && !nib_ack)  wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q <= '0;
      terr_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      terr_q <= terr_q | tmo;
    end
  end

  assign timeout_err = terr_q;
`else
  // Without the timeout build the FSM waits on nib_ack forever; this never fires.
  assign tmo = (TIMEOUT < 0);
`endif

  assign cfg_out   = cfg_q;
  assign nib_valid = nib_valid_q;
  assign nib_data  = nib_data_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign level     = fifo_level;

endmodule
